// File: rtl/dm_bus_arbiter.sv
// Data-memory port arbiter: CPU memory stage vs. a secondary master (DMA/debug), one
// transaction at a time through IDLE/ISSUE/WAIT/RESP. Define ARB_STARVE_GUARD_EN to enable D anti-starvation.
module dm_bus_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_byteen,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_LIM > 15) begin : g_param_chk
    $error("dm_bus_arbiter: MEM_LAT must be 1..15 and STARVE_LIM must fit 4 bits");
  end

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_win, c_win;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] SLIM4 = 4'(STARVE_LIM);
  logic [3:0] starve_cnt_q, starve_cnt_d;
  // D overrides a simultaneous CPU request once it has lost STARVE_LIM times in a row
  assign d_win = d_req & (~c_req | (starve_cnt_q == SLIM4));
`else
  assign d_win = d_req & ~c_req;
`endif
  assign c_win = c_req & ~d_win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    wait_cnt_d = wait_cnt_q;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (c_win || d_win) begin
          state_d  = S_ISSUE;
          owner_d  = d_win;
          we_d     = d_win ? d_we     : c_we;
          addr_d   = d_win ? d_addr   : c_addr;
          wdata_d  = d_win ? d_wdata  : c_wdata;
          byteen_d = d_win ? d_byteen : c_byteen;
        end
`ifdef ARB_STARVE_GUARD_EN
        if (d_win)              starve_cnt_d = '0;
        else if (c_req & d_req) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
      end
      S_ISSUE: begin
        wait_cnt_d = LAT4;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          // writes return no data, so the reply is zero regardless of the bus
          if (owner_q) d_rdata_d = we_q ? '0 : mem_rdata;
          else         c_rdata_d = we_q ? '0 : mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
      wait_cnt_q <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      wait_cnt_q <= wait_cnt_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // stall/grant are combinational on the requests, so gate them while reset is held
  assign c_stall    = ~reset & c_req & ~((state_q == S_RESP) & ~owner_q);
  assign d_gnt      = ~reset & (state_q == S_IDLE) & d_win;
  assign d_rvalid   = (state_q == S_RESP) & owner_q;
  assign mem_en     = (state_q == S_ISSUE);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_byteen = byteen_q;
  assign c_rdata    = c_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign owner      = owner_q;

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
Arbitrates a single data-memory port between two masters: the CPU memory-access stage and a secondary master such as DMA or debug. The block runs a per-transaction FSM (IDLE, ISSUE, WAIT, RESP) with a fixed memory latency. It stalls the pipeline while a CPU access is outstanding and gives the secondary master a req/gnt/rvalid handshake. It sits between the pipeline's memory stage and the external data memory.

Parameters:
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle until mem_rdata is valid (legal range 1..15).
STARVE_LIM, 8, consecutive lost arbitrations after which master D wins (used only with ARB_STARVE_GUARD_EN).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
c_req  in  1  CPU access request; held stable while c_stall=1
c_we  in  1  CPU write (1) / read (0)
c_addr  in  32  CPU byte address
c_wdata  in  32  CPU write data, pre-shifted to byte lanes
c_byteen  in  4  CPU byte enables
c_stall  out  1  freeze pipeline: CPU access not yet complete
c_rdata  out  32  CPU read data, valid in the CPU RESP cycle
d_req  in  1  secondary-master request; fields held until d_gnt
d_we  in  1  secondary-master write
d_addr  in  32  secondary-master address
d_wdata  in  32  secondary-master write data
d_byteen  in  4  secondary-master byte enables
d_gnt  out  1  one-cycle pulse: D request accepted
d_rvalid  out  1  one-cycle pulse: D transaction complete
d_rdata  out  32  D read data, valid while d_rvalid=1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe (mem_en & write)
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_byteen  out  4  memory byte enables
mem_rdata  in  32  memory read data
owner  out  1  current transaction owner: 0 = CPU, 1 = D

Behaviour:
- Reset (async, active-high) forces IDLE. All outputs are 0. Internal wait and starve counters are 0. Any in-flight transaction is dropped without a response.
- Arbitration happens only in IDLE, evaluated on the current cycle's requests.
  - c_req=1: CPU wins.
  - c_req=0 and d_req=1: D wins and d_gnt=1 combinationally in that cycle.
  - Winner's fields, owner and we are registered on the edge, and the FSM moves to ISSUE.
- ISSUE, 1 cycle: mem_en=1, mem_we=registered we. Address, data and byteen come from registers. wait_cnt is loaded with MEM_LAT. Next state is WAIT.
- WAIT, exactly MEM_LAT cycles: mem_en=0. mem_addr, mem_wdata and mem_byteen hold their last values. wait_cnt decrements each cycle. On the cycle wait_cnt==1, mem_rdata is captured into the rdata register, and the next state is RESP.
- RESP, 1 cycle:
  - Owner CPU: c_stall=0 and c_rdata=captured data.
  - Owner D: d_rvalid=1 and d_rdata=captured data.
  - For writes the captured data is forced to 0.
  - Next state is IDLE. No arbitration happens in RESP, so a still-high c_req cannot re-issue.
- c_stall = c_req & ~(state==RESP & owner==CPU). A CPU access therefore costs MEM_LAT+2 stall cycles (arbitration cycle, ISSUE, MEM_LAT WAIT cycles), followed by a RESP cycle without stall.
- c_rdata and d_rdata hold their value outside RESP. Only the RESP cycle is architecturally valid.
- Back-to-back: after RESP, IDLE lasts at least one cycle before the next grant. Minimum transaction period is MEM_LAT+3 cycles.
- D waiting while the CPU is served: d_req stays high and d_gnt stays 0. D must not change its fields until d_gnt.
- d_req dropped before d_gnt: the request is withdrawn with no side effect.
- With MEM_LAT=1, WAIT is a single cycle.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - starve_cnt, 4 bits, increments on each IDLE arbitration where d_req=1 and the CPU wins.
  - When starve_cnt==STARVE_LIM, D wins over a simultaneous c_req; the CPU keeps stalling.
  - starve_cnt clears on every D grant and on reset.
- Undefined: strict CPU priority and no starve counter. D can starve indefinitely.

Test Plan:
- MEM_LAT=1, CPU read of addr 0x10, memory returns 0xDEADBEEF -> c_stall high for 3 cycles, then c_rdata=0xDEADBEEF with c_stall=0; mem_en pulses once with mem_addr=0x10 and mem_we=0.
- MEM_LAT=3, CPU write of 0x12345678 to 0x20 with byteen 4'b1111 -> one mem_en and mem_we pulse with correct fields; c_stall high for 5 cycles; c_rdata=0 in RESP.
- D read of 0x40 alone, MEM_LAT=2 -> d_gnt in request cycle; d_rvalid exactly 4 cycles later; d_rdata equals memory data; owner=1 during transaction.
- c_req and d_req both high in IDLE, macro off -> CPU served first; d_gnt asserted in the IDLE cycle after the CPU RESP; d_rvalid follows.
- Macro on, STARVE_LIM=2, c_req and d_req held high continuously -> two CPU transactions, then D granted at the third arbitration, then CPU again.
- Reset asserted mid-WAIT -> all outputs 0 immediately; no RESP pulse; the next request after reset release completes normally.
